// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone slave memory.
//   cti_e   : cycle type identifier encodings that the slave acts on
//   bte_e   : burst type extension encodings
//   state_e : slave FSM states (also exported on the debug port)
//   next_index(): next burst word index for a given cti/bte
package wb_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACK   = 2'd2,
    S_BURST = 2'd3
  } state_e;

  // Index arithmetic is done at a fixed, generous width so a linear
  // increment past the top of the index field still shows up as out of range.
  localparam int IDX_W = 64;

  function automatic logic is_reserved_cti(input logic [2:0] cti);
    return (cti >= 3'b011) && (cti <= 3'b110);
  endfunction

  // Wrapping bursts only advance the low index bits; upper bits are held.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                  input logic [2:0]       cti,
                                                  input logic [1:0]       bte);
    logic [IDX_W-1:0] n;
    n = idx;
    if (cti == CTI_INCR) begin
      case (bte)
        BTE_LINEAR: n = idx + 64'd1;
        BTE_WRAP4:  n[1:0] = idx[1:0] + 2'd1;
        BTE_WRAP8:  n[2:0] = idx[2:0] + 3'd1;
        default:    n[3:0] = idx[3:0] + 4'd1;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/wb_burst_addr.sv
// Burst address generator for wb_slave_mem.
//   clk, rst         : clock, asynchronous active-low reset
//   load, load_idx   : capture the starting word index of a new cycle
//   adv              : step to the next beat index (after an acked beat)
//   cti, bte         : latched cycle type / burst type of the current cycle
//   cur_idx, nxt_idx : index of the last accepted beat and of the next beat
//   load_oor, cur_oor, nxt_oor : index >= DEPTH flags
module wb_burst_addr
  import wb_pkg::*;
#(
  parameter int IW    = 30,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  input  logic          adv,
  input  logic [2:0]    cti,
  input  logic [1:0]    bte,
  output logic [IW-1:0] cur_idx,
  output logic [IW-1:0] nxt_idx,
  output logic          load_oor,
  output logic          cur_oor,
  output logic          nxt_oor
);

  logic [IDX_W-1:0] nxt_full;

  assign nxt_full = next_index(IDX_W'(cur_idx), cti, bte);
  assign nxt_idx  = nxt_full[IW-1:0];
  assign nxt_oor  = nxt_full >= IDX_W'(DEPTH);
  assign cur_oor  = IDX_W'(cur_idx) >= IDX_W'(DEPTH);
  assign load_oor = IDX_W'(load_idx) >= IDX_W'(DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_idx <= '0;
    end else if (load) begin
      cur_idx <= load_idx;
    end else if (adv) begin
      cur_idx <= nxt_idx;
    end
  end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B3 slave memory with byte lanes, wait states and
// registered-feedback constant/incrementing/wrapping bursts.
//   clk, rst      : clock, asynchronous active-low reset
//   adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, cti_i, bte_i : Wishbone inputs
//   dat_o         : registered read data (0 on error)
//   ack_o, err_o  : normal / error termination, never together
//   rty_o         : retry, tied low
//   state_dbg     : current FSM state (wb_pkg::state_e encoding)
// Handshake: a beat is accepted on a rising edge where the slave is ready
// for it and cyc_i & stb_i are high; ack_o/err_o for that beat are visible
// for the following cycle, and write data/lanes are sampled on that edge.
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int INIT_INDEX  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW-1:0]   dat_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic            we_i,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic [2:0]      cti_i,
  input  logic [1:0]      bte_i,
  output logic [DW-1:0]   dat_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            rty_o,
  output logic [1:0]      state_dbg
);

  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = AW - LSB;
  localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WLAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e          state;
  logic [3:0]      wcnt;
  logic            lat_we;
  logic [2:0]      lat_cti;
  logic [1:0]      lat_bte;

  logic [IW-1:0]   adr_idx;
  logic [IW-1:0]   cur_idx;
  logic [IW-1:0]   nxt_idx;
  logic            adr_oor;
  logic            cur_oor;
  logic            nxt_oor;

  logic            beat_go;
  logic [IW-1:0]   beat_idx;
  logic            beat_oor;
  logic [2:0]      beat_cti;
  logic            beat_we;
  logic            beat_err;
  state_e          first_next;

  logic [DW-1:0]   mem [DEPTH];
  logic [MW-1:0]   mem_idx;
  logic [DW-1:0]   mem_rd;
  logic            wr_en;
  logic            unused_ok;

  assign adr_idx   = adr_i[AW-1:LSB];
  assign rty_o     = 1'b0;
  assign state_dbg = state;
  assign unused_ok = &{1'b0, adr_i, beat_idx};

  wb_burst_addr #(.IW(IW), .DEPTH(DEPTH)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == S_IDLE) && cyc_i && stb_i),
    .load_idx (adr_idx),
    .adv      (beat_go && !beat_err && (state == S_BURST)),
    .cti      (lat_cti),
    .bte      (lat_bte),
    .cur_idx  (cur_idx),
    .nxt_idx  (nxt_idx),
    .load_oor (adr_oor),
    .cur_oor  (cur_oor),
    .nxt_oor  (nxt_oor)
  );

  // Which beat (if any) completes on the coming edge. In IDLE with no wait
  // states the bus address is used directly; in a burst the next index is
  // prefetched so the ack carries that beat's data.
  always_comb begin
    beat_go  = 1'b0;
    beat_idx = adr_idx;
    beat_oor = adr_oor;
    beat_cti = cti_i;
    beat_we  = we_i;
    case (state)
      S_IDLE: beat_go = cyc_i && stb_i && (WAIT_STATES == 0);
      S_WAIT: begin
        beat_go  = cyc_i && stb_i && (wcnt == WLAST);
        beat_idx = cur_idx;
        beat_oor = cur_oor;
        beat_cti = lat_cti;
        beat_we  = lat_we;
      end
      S_BURST: begin
        beat_go  = cyc_i && stb_i;
        beat_idx = nxt_idx;
        beat_oor = nxt_oor;
        beat_cti = lat_cti;
        beat_we  = lat_we;
      end
      default: ;
    endcase
    // Gate with reset so an unreset memory cannot take a write while held.
    beat_go  = beat_go && rst;
    beat_err = beat_oor || is_reserved_cti(beat_cti);
    first_next = (beat_err || !((beat_cti == CTI_CONST) || (beat_cti == CTI_INCR)))
                 ? S_ACK : S_BURST;
  end

  assign mem_idx = beat_idx[MW-1:0];
  assign mem_rd  = mem[mem_idx];
  assign wr_en   = beat_go && !beat_err && beat_we;

  generate
    if (INIT_INDEX != 0) begin : g_init
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i);
        end else if (wr_en) begin
          for (int b = 0; b < SW; b++)
            if (sel_i[b]) mem[mem_idx][8*b +: 8] <= dat_i[8*b +: 8];
        end
      end
    end else begin : g_noinit
      always_ff @(posedge clk) begin
        if (wr_en) begin
          for (int b = 0; b < SW; b++)
            if (sel_i[b]) mem[mem_idx][8*b +: 8] <= dat_i[8*b +: 8];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      dat_o   <= '0;
      wcnt    <= '0;
      lat_we  <= 1'b0;
      lat_cti <= 3'b000;
      lat_bte <= 2'b00;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (beat_go) begin
        if (beat_err) begin
          err_o <= 1'b1;
          dat_o <= '0;
        end else begin
          ack_o <= 1'b1;
          if (!beat_we) dat_o <= mem_rd;
        end
      end
      case (state)
        S_IDLE: begin
          if (cyc_i && stb_i) begin
            lat_we  <= we_i;
            lat_cti <= cti_i;
            lat_bte <= bte_i;
            wcnt    <= '0;
            state   <= (WAIT_STATES == 0) ? first_next : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!cyc_i)              state <= S_IDLE;
          else if (beat_go)        state <= first_next;
          else if (wcnt != WLAST)  wcnt  <= wcnt + 4'd1;
        end
        // One dead cycle after every termination: no back-to-back classic acks.
        S_ACK: state <= S_IDLE;
        S_BURST: begin
          if (!cyc_i)       state <= S_IDLE;
          else if (beat_go) state <= (beat_err || (cti_i == CTI_EOB)) ? S_ACK : S_BURST;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: three instances share one bus, selected by cyc.
//   [0] WAIT_STATES=0, INIT_INDEX=1   [1] WAIT_STATES=3, INIT_INDEX=1
//   [2] WAIT_STATES=0, INIT_INDEX=0
module tb_wb_slave_mem;
  import wb_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      adr_i = '0;
  logic [31:0]      dat_i = '0;
  logic [3:0]       sel_i = '0;
  logic             we_i  = 1'b0;
  logic             stb_i = 1'b0;
  logic [2:0]       cti_i = '0;
  logic [1:0]       bte_i = '0;
  logic [2:0]       cyc_w = '0;
  logic [2:0]       ack_w, err_w, rty_w;
  logic [2:0][31:0] dat_w;
  logic [2:0][1:0]  st_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_slave_mem #(.WAIT_STATES(0), .INIT_INDEX(1)) u_dut0 (
    .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .we_i(we_i),
    .cyc_i(cyc_w[0]), .stb_i(stb_i), .cti_i(cti_i), .bte_i(bte_i),
    .dat_o(dat_w[0]), .ack_o(ack_w[0]), .err_o(err_w[0]), .rty_o(rty_w[0]), .state_dbg(st_w[0]));

  wb_slave_mem #(.WAIT_STATES(3), .INIT_INDEX(1)) u_dut_ws (
    .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .we_i(we_i),
    .cyc_i(cyc_w[1]), .stb_i(stb_i), .cti_i(cti_i), .bte_i(bte_i),
    .dat_o(dat_w[1]), .ack_o(ack_w[1]), .err_o(err_w[1]), .rty_o(rty_w[1]), .state_dbg(st_w[1]));

  wb_slave_mem #(.WAIT_STATES(0), .INIT_INDEX(0)) u_dut_ni (
    .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .we_i(we_i),
    .cyc_i(cyc_w[2]), .stb_i(stb_i), .cti_i(cti_i), .bte_i(bte_i),
    .dat_o(dat_w[2]), .ack_o(ack_w[2]), .err_o(err_w[2]), .rty_o(rty_w[2]), .state_dbg(st_w[2]));

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic        exp_ack;
    logic        exp_err;
    logic        chk_dat;
    logic [31:0] exp_dat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [2:0] cti, input logic e_ack,
                              input logic e_err, input logic chk, input logic [31:0] e_dat);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.cti = cti;
    v.exp_ack = e_ack; v.exp_err = e_err; v.chk_dat = chk; v.exp_dat = e_dat;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Single classic cycle on instance t; latency counted in edges from strobe.
  task automatic classic(input int t, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] c, input int exp_lat,
                         input logic e_ack, input logic e_err, input logic chk,
                         input logic [31:0] e_dat, input string nm);
    int lat;
    lat = -1;
    adr_i = a; dat_i = d; sel_i = s; we_i = we; cti_i = c; bte_i = 2'b00; stb_i = 1'b1;
    cyc_w = '0; cyc_w[t] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack_w[t] || err_w[t]) begin
        lat = n;
        break;
      end
    end
    check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    check({nm, "_ack"}, 32'(ack_w[t]), 32'(e_ack));
    check({nm, "_err"}, 32'(err_w[t]), 32'(e_err));
    check({nm, "_both"}, 32'(ack_w[t] & err_w[t]), 32'd0);
    if (chk) check({nm, "_dat"}, dat_w[t], e_dat);
    cyc_w = '0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
    @(posedge clk); #1;
    check({nm, "_drop"}, 32'(ack_w[t] | err_w[t]), 32'd0);
  endtask

  task automatic burst_start(input int t, input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] c, input logic [1:0] b);
    adr_i = a; dat_i = d; sel_i = 4'hF; we_i = we; cti_i = c; bte_i = b; stb_i = 1'b1;
    cyc_w = '0; cyc_w[t] = 1'b1;
  endtask

  task automatic beat(input int t, input logic e_ack, input logic e_err, input logic chk,
                      input logic [31:0] e_dat, input string nm);
    @(posedge clk); #1;
    check({nm, "_ack"}, 32'(ack_w[t]), 32'(e_ack));
    check({nm, "_err"}, 32'(err_w[t]), 32'(e_err));
    if (chk) check({nm, "_dat"}, dat_w[t], e_dat);
  endtask

  task automatic burst_end();
    cyc_w = '0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000; bte_i = 2'b00;
  endtask

  vec_t vecs [11];
  logic [31:0] wexp [4];

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1'b0, 32'h010, 32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 1'b1, 32'h4);
    vecs[1]  = mk(1'b1, 32'h020, 32'hAABBCCDD, 4'h5, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 32'h020, 32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 1'b1, 32'h00BB00DD);
    vecs[3]  = mk(1'b0, 32'h400, 32'h0,        4'hF, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0);
    vecs[4]  = mk(1'b0, 32'h014, 32'h0,        4'h0, 3'b111, 1'b1, 1'b0, 1'b1, 32'h5);
    vecs[5]  = mk(1'b0, 32'h010, 32'h0,        4'hF, 3'b011, 1'b0, 1'b1, 1'b1, 32'h0);
    vecs[6]  = mk(1'b1, 32'h3FC, 32'h12345678, 4'hF, 3'b111, 1'b1, 1'b0, 1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 32'h3FC, 32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 1'b1, 32'h12345678);
    vecs[8]  = mk(1'b1, 32'h404, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0);
    vecs[9]  = mk(1'b0, 32'h01C, 32'h0,        4'hF, 3'b000, 1'b1, 1'b0, 1'b1, 32'h7);
    vecs[10] = mk(1'b0, 32'h018, 32'h0,        4'hF, 3'b110, 1'b0, 1'b1, 1'b1, 32'h0);
    wexp[0] = 32'd6; wexp[1] = 32'd7; wexp[2] = 32'd4; wexp[3] = 32'd5;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_ack", 32'(ack_w), 32'd0);
    check("rst_err", 32'(err_w), 32'd0);
    check("rst_rty", 32'(rty_w), 32'd0);
    check("rst_dat0", dat_w[0], 32'd0);
    check("rst_state0", 32'(st_w[0]), 32'(S_IDLE));
    rst = 1'b1;
    @(posedge clk); #1;

    // Classic table on the zero-wait instance
    for (int i = 0; i < 11; i++)
      classic(0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].cti, 1,
              vecs[i].exp_ack, vecs[i].exp_err, vecs[i].chk_dat, vecs[i].exp_dat,
              $sformatf("v%0d", i));

    // Wait-state instance: latency 4 edges from strobe
    classic(1, 1'b0, 32'h08, 32'h0, 4'hF, 3'b000, 4, 1'b1, 1'b0, 1'b1, 32'h2, "ws_rd2");
    classic(1, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hC, 3'b000, 4, 1'b1, 1'b0, 1'b0, 32'h0, "ws_wr3");
    classic(1, 1'b0, 32'h0C, 32'h0, 4'hF, 3'b000, 4, 1'b1, 1'b0, 1'b1, 32'hCAFE0003, "ws_rd3");

    // WRAP4 read burst from index 6: 6,7,4,5
    burst_start(0, 1'b0, 32'h18, 32'h0, 3'b010, 2'b01);
    for (int k = 0; k < 4; k++) begin
      beat(0, 1'b1, 1'b0, 1'b1, wexp[k], $sformatf("wrap4_b%0d", k));
      if (k == 2) cti_i = 3'b111;
    end
    burst_end();
    beat(0, 1'b0, 1'b0, 1'b0, 32'h0, "wrap4_end");
    check("wrap4_idle", 32'(st_w[0]), 32'(S_IDLE));

    // Linear read burst with a stb wait inserted after beat 2
    burst_start(0, 1'b0, 32'h50, 32'h0, 3'b010, 2'b00);
    beat(0, 1'b1, 1'b0, 1'b1, 32'd20, "lin_b0");
    beat(0, 1'b1, 1'b0, 1'b1, 32'd21, "lin_b1");
    stb_i = 1'b0;
    beat(0, 1'b0, 1'b0, 1'b0, 32'h0, "lin_wait");
    stb_i = 1'b1; cti_i = 3'b111;
    beat(0, 1'b1, 1'b0, 1'b1, 32'd22, "lin_b2");
    burst_end();
    beat(0, 1'b0, 1'b0, 1'b0, 32'h0, "lin_end");

    // Linear burst running off the end of memory
    burst_start(0, 1'b0, 32'h3F8, 32'h0, 3'b010, 2'b00);
    beat(0, 1'b1, 1'b0, 1'b1, 32'd254, "oor_b0");
    beat(0, 1'b1, 1'b0, 1'b1, 32'h12345678, "oor_b1");
    beat(0, 1'b0, 1'b1, 1'b1, 32'h0, "oor_b2");
    burst_end();
    beat(0, 1'b0, 1'b0, 1'b0, 32'h0, "oor_end");

    // Constant-address write burst, then read back
    burst_start(0, 1'b1, 32'h40, 32'h11111111, 3'b001, 2'b00);
    beat(0, 1'b1, 1'b0, 1'b0, 32'h0, "const_b0");
    dat_i = 32'h22222222; cti_i = 3'b111;
    beat(0, 1'b1, 1'b0, 1'b0, 32'h0, "const_b1");
    burst_end();
    beat(0, 1'b0, 1'b0, 1'b0, 32'h0, "const_end");
    classic(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'b000, 1, 1'b1, 1'b0, 1'b1, 32'h22222222, "const_rd16");
    classic(0, 1'b0, 32'h44, 32'h0, 4'hF, 3'b000, 1, 1'b1, 1'b0, 1'b1, 32'd17, "const_rd17");

    // Reset in the middle of a linear write burst (uninitialised instance)
    classic(2, 1'b1, 32'h30, 32'h33333333, 4'hF, 3'b000, 1, 1'b1, 1'b0, 1'b0, 32'h0, "ni_pre_wr");
    classic(2, 1'b0, 32'h30, 32'h0, 4'hF, 3'b000, 1, 1'b1, 1'b0, 1'b1, 32'h33333333, "ni_pre_rd");
    burst_start(2, 1'b1, 32'h28, 32'hA0A0A0A0, 3'b010, 2'b00);
    beat(2, 1'b1, 1'b0, 1'b0, 32'h0, "ni_b0");
    dat_i = 32'hB1B1B1B1;
    beat(2, 1'b1, 1'b0, 1'b0, 32'h0, "ni_b1");
    dat_i = 32'hC2C2C2C2;
    rst = 1'b0;
    #1;
    check("ni_rst_ack", 32'(ack_w[2]), 32'd0);
    check("ni_rst_err", 32'(err_w[2]), 32'd0);
    check("ni_rst_dat", dat_w[2], 32'h0);
    check("ni_rst_state", 32'(st_w[2]), 32'(S_IDLE));
    @(posedge clk); @(posedge clk); #1;
    burst_end();
    rst = 1'b1;
    @(posedge clk); #1;
    classic(2, 1'b0, 32'h28, 32'h0, 4'hF, 3'b000, 1, 1'b1, 1'b0, 1'b1, 32'hA0A0A0A0, "ni_rd10");
    classic(2, 1'b0, 32'h2C, 32'h0, 4'hF, 3'b000, 1, 1'b1, 1'b0, 1'b1, 32'hB1B1B1B1, "ni_rd11");
    classic(2, 1'b0, 32'h30, 32'h0, 4'hF, 3'b000, 1, 1'b1, 1'b0, 1'b1, 32'h33333333, "ni_rd12");
    check("end_rty", 32'(rty_w), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
